// File: rtl/gpio_pkg.sv
// Shared GPIO register map: output block constants plus the input block's address map
// and the per-bit edge report carried from gpio_in_bit to gpio_in_ip.
package gpio_pkg;

  // GPIO output block register map
  localparam logic [1:0] GPIO_OUT_ADDR_DATA = 2'd0;
  localparam logic [1:0] GPIO_OUT_ADDR_SET  = 2'd1;
  localparam logic [1:0] GPIO_OUT_ADDR_CLR  = 2'd2;
  localparam logic [1:0] GPIO_OUT_ADDR_DIR  = 2'd3;

  // GPIO input block register map
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_RISE_EN = 2'd2;
  localparam logic [1:0] ADDR_FALL_EN = 2'd3;

  localparam int DBNC_CNT_W = 8;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;

endpackage

// File: rtl/gpio_in_bit.sv
// One input pin: two-flop synchronizer, optional debounce (GPIO_IN_DEBOUNCE_EN) and
// edge detection; edges are reported in the cycle before level_o takes the new value.
module gpio_in_bit
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic  clk,
  input  logic  resetn,
  input  logic  pin_i,
  output logic  level_o,
  output edge_t edge_o
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_cfg
    $error("gpio_in_bit: DEBOUNCE_CYCLES out of range 2..255");
  end

  logic s1_q, s2_q;
  logic data_q, data_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      data_q <= 1'b0;
    end else begin
      s1_q   <= pin_i;
      s2_q   <= s1_q;
      data_q <= data_d;
    end
  end

`ifdef GPIO_IN_DEBOUNCE_EN
  logic [DBNC_CNT_W-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronized pin disagrees with the accepted level.
  always_comb begin
    cnt_d  = '0;
    data_d = data_q;
    if (s2_q != data_q) begin
      if (cnt_q == DBNC_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        data_d = s2_q;
      end else begin
        cnt_d = cnt_q + DBNC_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign data_d = s2_q;
`endif

  assign level_o     = data_q;
  assign edge_o.rise = data_d & ~data_q;
  assign edge_o.fall = ~data_d & data_q;

endmodule

// File: rtl/gpio_in_ip.sv
// GPIO input block: per-pin conditioning in gpio_in_bit, sticky W1C event status,
// rise/fall enables, combinational read mux and level irq. Debounce via GPIO_IN_DEBOUNCE_EN.
module gpio_in_ip
  import gpio_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             write_en,
  input  logic             read_en,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_cfg
    $error("gpio_in_ip: WIDTH out of range 1..32");
  end

  logic [WIDTH-1:0] data_w, rise_w, fall_w;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  edge_t            edge_w [WIDTH];
  logic             unused_wdata;

  assign unused_wdata = ^wdata;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    gpio_in_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .resetn (resetn),
      .pin_i  (gpio_in[gi]),
      .level_o(data_w[gi]),
      .edge_o (edge_w[gi])
    );
    assign rise_w[gi] = edge_w[gi].rise;
    assign fall_w[gi] = edge_w[gi].fall;
  end

  // Hardware set is OR-ed in after the W1C mask so a same-cycle set wins.
  always_comb begin
    status_d  = status_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    if (write_en) begin
      case (addr)
        ADDR_STATUS:  status_d  = status_q & ~wdata[WIDTH-1:0];
        ADDR_RISE_EN: rise_en_d = wdata[WIDTH-1:0];
        ADDR_FALL_EN: fall_en_d = wdata[WIDTH-1:0];
        default:      ;
      endcase
    end
    status_d = status_d | (rise_w & rise_en_q) | (fall_w & fall_en_q);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      status_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else begin
      status_q  <= status_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (read_en) begin
      case (addr)
        ADDR_DATA:    rdata[WIDTH-1:0] = data_w;
        ADDR_STATUS:  rdata[WIDTH-1:0] = status_q;
        ADDR_RISE_EN: rdata[WIDTH-1:0] = rise_en_q;
        default:      rdata[WIDTH-1:0] = fall_en_q;
      endcase
    end
  end

  assign irq = |status_q;

endmodule

// File: doc/gpio_in_ip.md
GPIO_IN_IP -- requirements
Module: gpio_in_ip

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: number of input pins, range 1..32.
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required before a level change is accepted, range 2..255.
REQ-003 SHALL provide port clk, input, 1: single clock, all state on its rising edge.
REQ-004 SHALL provide port resetn, input, 1: reset, synchronous and active-low.
REQ-005 SHALL provide port write_en, input, 1: register write strobe.
REQ-006 SHALL provide port read_en, input, 1: register read strobe.
REQ-007 SHALL provide port addr, input, 2: register select (0 DATA, 1 STATUS, 2 RISE_EN, 3 FALL_EN).
REQ-008 SHALL provide port wdata, input, 32: write data.
REQ-009 SHALL provide port rdata, output, 32: read data.
REQ-010 SHALL provide port gpio_in, input, WIDTH: asynchronous external pins.
REQ-011 SHALL provide port irq, output, 1: level interrupt.

Function
REQ-012 SHALL pass each gpio_in bit through a two-flop synchronizer (s1, s2) before any other use.
REQ-013 SHALL hold the accepted level per bit in data_q; without debounce, data_q takes s2 every cycle, so a pin change is visible in DATA on the 3rd rising edge after it.
REQ-014 SHALL detect an edge on a bit in the cycle data_q changes: 0->1 is rising, 1->0 is falling.
REQ-015 SHALL set STATUS[i] on a rising edge when RISE_EN[i]=1, or on a falling edge when FALL_EN[i]=1; events on disabled edges are dropped and not stored.
REQ-016 SHALL keep STATUS bits sticky until cleared by a write to addr 1 with the bit set in wdata (write-1-to-clear); wdata 0 bits leave STATUS unchanged.
REQ-017 SHALL let a set win over a clear when a hardware set and a W1C hit the same STATUS bit in the same cycle.
REQ-018 SHALL make RISE_EN and FALL_EN read/write; writes to them take effect on the next clock edge.
REQ-019 SHALL ignore writes to addr 0 (DATA is read-only).
REQ-020 SHALL drive rdata combinationally: selected register zero-extended to 32 bits when read_en=1, else 32'b0.
REQ-021 SHALL drive irq combinationally as the OR of STATUS[WIDTH-1:0], asserting in the same cycle the STATUS bit sets.
REQ-022 SHALL, for simultaneous read_en and write_en to the same address, return the pre-write value on rdata.

Reset
REQ-023 SHALL clear s1, s2, data_q, STATUS, RISE_EN, FALL_EN and all debounce counters on any clock edge with resetn=0, including mid-debounce; irq=0 and rdata=0 (when read_en=0) follow directly.
REQ-024 SHALL NOT flag a pin held high across reset release unless RISE_EN was written to 1 before data_q rises.

Configuration
REQ-025 SHALL use macro GPIO_IN_DEBOUNCE_EN: if defined, each bit has a counter that increments while s2!=data_q and clears when s2==data_q; data_q updates when s2 has differed for DEBOUNCE_CYCLES consecutive cycles; a glitch shorter than that is discarded with no STATUS change.
REQ-026 SHALL, with GPIO_IN_DEBOUNCE_EN undefined, instantiate no counters and behave as REQ-013.

Structure
REQ-027 SHALL place the register address constants (ADDR_DATA=0, ADDR_STATUS=1, ADDR_RISE_EN=2, ADDR_FALL_EN=3) in shared package gpio_pkg, alongside the existing GPIO output address constants.
REQ-028 SHALL implement per-bit synchronizer, optional debounce and edge detection in sub-module gpio_in_bit, instantiated WIDTH times with a generate loop; registers, rdata mux and irq stay at top level.

Verification
REQ-029 SHALL cover, without debounce: RISE_EN=0x1, gpio_in[0] 0->1 at cycle 0 -> DATA=0x1 and STATUS=0x1 at cycle 3, irq=1.
REQ-030 SHALL cover W1C: STATUS=0x3, write addr1 wdata=0x1 -> STATUS=0x2, irq stays 1; write 0x2 -> STATUS=0, irq=0.
REQ-031 SHALL cover the same-cycle race: W1C of bit 0 in the same cycle a new enabled rising edge occurs on bit 0 -> STATUS[0]=1.
REQ-032 SHALL cover debounce with DEBOUNCE_CYCLES=4: a 3-cycle high pulse -> DATA and STATUS unchanged; a 4-cycle-stable high -> DATA[0]=1 exactly 4 cycles after s2 rises.
REQ-033 SHALL cover disabled edges and reset: FALL_EN=0, pin 1->0 -> DATA=0, STATUS=0; resetn=0 for 1 cycle mid-debounce -> all registers 0, irq=0.
REQ-034 SHALL cover the read port: read_en=0 -> rdata=0; read addr2 after writing 0xFFFF_FFFF with WIDTH=8 -> rdata=0x0000_00FF.
